// File: rtl/dpwm_value_select_if.sv
// Select-code inputs and registered count outputs of the DPWM value-generation stage.
interface dpwm_value_select_if;
  logic [4:0]  i_duty_sel;
  logic [3:0]  i_dt1_sel;
  logic [3:0]  i_dt2_sel;
  logic [3:0]  i_freq_sel;
  logic        i_ts_last;
  logic [11:0] o_ton;
  logic [11:0] o_ts;
  logic [4:0]  o_dt1;
  logic [4:0]  o_dt2;

  modport master (
    output i_duty_sel, i_dt1_sel, i_dt2_sel, i_freq_sel, i_ts_last,
    input  o_ton, o_ts, o_dt1, o_dt2
  );

  modport slave (
    input  i_duty_sel, i_dt1_sel, i_dt2_sel, i_freq_sel, i_ts_last,
    output o_ton, o_ts, o_dt1, o_dt2
  );
endinterface

// File: rtl/dpwm_value_select.sv
// DPWM value generation: maps select codes to on-time/period/dead-time counts,
// loaded atomically only on the last clock of a switching period.
module dpwm_value_select (
  input  logic                 i_clk,
  input  logic                 i_reset,
  dpwm_value_select_if.slave   bus
);

  function automatic logic [11:0] ts_lookup(input logic [3:0] sel);
    logic [11:0] ts;
    case (sel)
      4'd0:    ts = 12'd4000;
      4'd1:    ts = 12'd3600;
      4'd2:    ts = 12'd3200;
      4'd3:    ts = 12'd2800;
      4'd4:    ts = 12'd2400;
      4'd5:    ts = 12'd2000;
      4'd6:    ts = 12'd1800;
      4'd7:    ts = 12'd1600;
      4'd8:    ts = 12'd1400;
      4'd9:    ts = 12'd1200;
      4'd10:   ts = 12'd1000;
      4'd11:   ts = 12'd800;
      4'd12:   ts = 12'd600;
      4'd13:   ts = 12'd500;
      4'd14:   ts = 12'd400;
      default: ts = 12'd200;
    endcase
    return ts;
  endfunction

  // Clamp keeps both dead times inside the period; limit is always positive.
  function automatic logic [11:0] sat_ton(input logic [11:0] raw, input logic [11:0] lim);
    return (raw > lim) ? lim : raw;
  endfunction

  logic [11:0] ts_nxt;
  logic [4:0]  dt1_nxt;
  logic [4:0]  dt2_nxt;
  logic [16:0] prod;
  logic [11:0] ton_raw;
  logic [11:0] ton_max;
  logic [11:0] ton_nxt;

  always_comb begin
    ts_nxt  = ts_lookup(bus.i_freq_sel);
    dt1_nxt = {bus.i_dt1_sel, 1'b1};
    dt2_nxt = {bus.i_dt2_sel, 1'b1};
    prod    = {5'd0, ts_nxt} * {12'd0, bus.i_duty_sel};
    ton_raw = prod[16:5];
    ton_max = ts_nxt - {7'd0, dt1_nxt} - {7'd0, dt2_nxt};
    ton_nxt = sat_ton(ton_raw, ton_max);
  end

  // Output register bank: only a clean 1 on the strobe loads.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bus.o_ts  <= 12'd4000;
      bus.o_ton <= 12'd0;
      bus.o_dt1 <= 5'd1;
      bus.o_dt2 <= 5'd1;
    end else if (bus.i_ts_last == 1'b1) begin
      bus.o_ts  <= ts_nxt;
      bus.o_ton <= ton_nxt;
      bus.o_dt1 <= dt1_nxt;
      bus.o_dt2 <= dt2_nxt;
    end
  end

endmodule

// File: tb/tb_dpwm_value_select.sv
// Directed-vector bench for dpwm_value_select with hand-computed expectations.
module tb_dpwm_value_select;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  dpwm_value_select_if bus ();

  dpwm_value_select dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ts, input int ton, input int dt1, input int dt2);
    chk({tag, ".ts"},  32'(bus.o_ts),  32'(ts));
    chk({tag, ".ton"}, 32'(bus.o_ton), 32'(ton));
    chk({tag, ".dt1"}, 32'(bus.o_dt1), 32'(dt1));
    chk({tag, ".dt2"}, 32'(bus.o_dt2), 32'(dt2));
  endtask

  task automatic set_sel(input int f, input int d, input int t1, input int t2);
    bus.i_freq_sel = 4'(f);
    bus.i_duty_sel = 5'(d);
    bus.i_dt1_sel  = 4'(t1);
    bus.i_dt2_sel  = 4'(t2);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe();
    bus.i_ts_last = 1'b1;
    tick(1);
    bus.i_ts_last = 1'b0;
  endtask

  int ts_tab [16] = '{4000, 3600, 3200, 2800, 2400, 2000, 1800, 1600,
                      1400, 1200, 1000, 800, 600, 500, 400, 200};

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.i_ts_last = 1'b0;
    set_sel(7, 20, 9, 2);

    // Reset hold with strobes toggling
    for (int i = 0; i < 4; i++) begin
      bus.i_ts_last = ~bus.i_ts_last;
      tick(1);
    end
    chk_all("reset_hold", 4000, 0, 1, 1);

    // Release: outputs hold until the first strobe
    rst_n = 1'b1;
    bus.i_ts_last = 1'b0;
    tick(3);
    chk_all("post_release", 4000, 0, 1, 1);

    set_sel(3, 5, 3, 5);
    strobe();
    chk_all("basic", 2800, 437, 7, 11);

    set_sel(0, 4, 5, 7);
    tick(20);
    chk_all("hold", 2800, 437, 7, 11);
    strobe();
    chk_all("reload", 4000, 500, 11, 15);

    set_sel(15, 31, 15, 15);
    strobe();
    chk_all("clamp", 200, 138, 31, 31);

    set_sel(5, 0, 4, 1);
    strobe();
    chk_all("zero_duty", 2000, 0, 9, 3);

    for (int f = 0; f < 16; f++) begin
      set_sel(f, 16, 0, 0);
      strobe();
      chk($sformatf("sweep%0d.ts", f),  32'(bus.o_ts),  32'(ts_tab[f]));
      chk($sformatf("sweep%0d.ton", f), 32'(bus.o_ton), 32'(ts_tab[f] / 2));
    end

    // Consecutive strobes track inputs with one-cycle latency
    bus.i_ts_last = 1'b1;
    set_sel(9, 8, 1, 0);
    tick(1);
    chk_all("consec1", 1200, 300, 3, 1);
    set_sel(2, 31, 0, 2);
    tick(1);
    chk_all("consec2", 3200, 3100, 1, 5);
    bus.i_ts_last = 1'b0;

    // Mid-operation asynchronous reset, observed before the next edge
    set_sel(12, 10, 6, 6);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4000, 0, 1, 1);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk_all("after_reset_idle", 4000, 0, 1, 1);
    strobe();
    chk_all("after_reset_load", 600, 187, 13, 13);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
